// File: rtl/issue_scoreboard_pkg.sv
// Shared types and constants for the issue scoreboard.
package hazard_definitions;

  localparam int unsigned SB_DEPTH_DEFAULT = 4;
  localparam logic [4:0]  REG_X0           = 5'd0;

  typedef struct packed {
    logic [4:0] rd;
    logic       is_load;
  } sb_entry_t;

endpackage

// File: rtl/issue_scoreboard_sb_match.sv
// Parallel compare of one source register against the candidate scoreboard entries.
module sb_match
  import hazard_definitions::*;
#(
  parameter int unsigned DEPTH = SB_DEPTH_DEFAULT
) (
  input  logic [4:0]             rs,
  input  logic [DEPTH-1:0][4:0]  rds,
  input  logic [DEPTH-1:0]       cand,
  output logic                   hit
);

  logic [DEPTH-1:0] match;

  always_comb begin
    match = '0;
    for (int i = 0; i < DEPTH; i++) begin
      match[i] = cand[i] && (rds[i] == rs);
    end
    hit = (rs != REG_X0) && (|match);
  end

endmodule

// File: rtl/issue_scoreboard.sv
// In-order scoreboard gating issue from decode; tracks in-flight destinations.
// Build option: SCOREBOARD_FWD_EN restricts hazard detection to in-flight loads.
module issue_scoreboard
  import hazard_definitions::*;
#(
  parameter int unsigned DEPTH = SB_DEPTH_DEFAULT
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        id_valid,
  input  logic [4:0]                  id_rs1,
  input  logic [4:0]                  id_rs2,
  input  logic                        id_uses_rs1,
  input  logic                        id_uses_rs2,
  input  logic [4:0]                  id_rd,
  input  logic                        id_RegWrite,
  input  logic                        id_MemRead,
  input  logic                        wb_RegWrite,
  input  logic [4:0]                  write_rd,
  input  logic                        flush,
  input  logic [1:0]                  flush_cnt,
  output logic                        id_stall,
  output logic [$clog2(DEPTH):0]      sb_count,
  output logic                        sb_full,
  output logic                        sb_empty,
  output logic                        sb_err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
`ifdef SCOREBOARD_FWD_EN
  localparam bit FWD_EN = 1'b1;
`else
  localparam bit FWD_EN = 1'b0;
`endif

  sb_entry_t [DEPTH-1:0] entries_q;
  logic [AW-1:0]         head_q, tail_q;
  logic [CW-1:0]         count_q;
  logic                  err_q;

  logic                  pop, pop_eff, pop_err, push;
  logic                  empty, full;
  logic [DEPTH-1:0]      cand;
  logic [DEPTH-1:0][4:0] rds;
  logic                  hit_rs1, hit_rs2;
  logic [CW-1:0]         count_ap, fc_w, drop, count_d;
  logic [AW-1:0]         head_d, tail_d;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign pop     = wb_RegWrite && (write_rd != REG_X0);
  assign pop_eff = pop && !empty;
  assign pop_err = pop && (empty || (entries_q[head_q].rd != write_rd));

  // Valid window from head, minus the head when it retires this cycle (WB bypass covers it).
  always_comb begin
    cand = '0;
    rds  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      rds[i]  = entries_q[i].rd;
      cand[i] = (CW'(AW'(AW'(i) - head_q)) < count_q)
                && !(pop_eff && (AW'(i) == head_q))
                && (entries_q[i].is_load || !FWD_EN);
    end
  end

  sb_match #(.DEPTH(DEPTH)) u_match_rs1 (
    .rs   (id_rs1),
    .rds  (rds),
    .cand (cand),
    .hit  (hit_rs1)
  );

  sb_match #(.DEPTH(DEPTH)) u_match_rs2 (
    .rs   (id_rs2),
    .rds  (rds),
    .cand (cand),
    .hit  (hit_rs2)
  );

  assign id_stall = id_valid && !flush &&
                    ((id_uses_rs1 && hit_rs1) || (id_uses_rs2 && hit_rs2) ||
                     (full && !pop && id_RegWrite));

  assign push = id_valid && !id_stall && !flush && id_RegWrite && (id_rd != REG_X0);

  // Pop is applied before the flush drop, which is clamped to what remains.
  always_comb begin
    count_ap = count_q - CW'(pop_eff);
    fc_w     = CW'(flush_cnt);
    drop     = '0;
    if (flush) begin
      drop = (fc_w < count_ap) ? fc_w : count_ap;
    end
    count_d  = count_ap + CW'(push) - drop;
    head_d   = head_q + AW'(pop_eff);
    tail_d   = tail_q + AW'(push) - AW'(drop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entries_q <= '0;
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      if (push) begin
        entries_q[tail_q] <= '{rd: id_rd, is_load: id_MemRead};
      end
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      if (pop_err) begin
        err_q <= 1'b1;
      end
    end
  end

  assign sb_count = count_q;
  assign sb_full  = full;
  assign sb_empty = empty;
  assign sb_err   = err_q;

endmodule

// File: tb/tb_issue_scoreboard.sv
// Directed stimulus with a queued expectation scoreboard checked at each negedge.
module tb_issue_scoreboard;

  localparam int unsigned DEPTH = 4;
`ifdef SCOREBOARD_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  localparam logic NF = !FWD;

  logic       clk, rst_n;
  logic       id_valid, id_uses_rs1, id_uses_rs2, id_RegWrite, id_MemRead;
  logic [4:0] id_rs1, id_rs2, id_rd, write_rd;
  logic       wb_RegWrite, flush;
  logic [1:0] flush_cnt;
  logic       id_stall, sb_full, sb_empty, sb_err;
  logic [2:0] sb_count;

  issue_scoreboard #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .id_valid    (id_valid),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_uses_rs1 (id_uses_rs1),
    .id_uses_rs2 (id_uses_rs2),
    .id_rd       (id_rd),
    .id_RegWrite (id_RegWrite),
    .id_MemRead  (id_MemRead),
    .wb_RegWrite (wb_RegWrite),
    .write_rd    (write_rd),
    .flush       (flush),
    .flush_cnt   (flush_cnt),
    .id_stall    (id_stall),
    .sb_count    (sb_count),
    .sb_full     (sb_full),
    .sb_empty    (sb_empty),
    .sb_err      (sb_err)
  );

  typedef struct {
    string nm;
    logic  stall;
    int    cnt;
    logic  err;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input string fld, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s.%s got=%0d exp=%0d", nm, fld, got, want);
    end
  endtask

  // Monitor: one expectation per driven cycle, sampled mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk(e.nm, "stall", int'(id_stall), int'(e.stall));
        chk(e.nm, "count", int'(sb_count), e.cnt);
        chk(e.nm, "full",  int'(sb_full),  int'(e.cnt == DEPTH));
        chk(e.nm, "empty", int'(sb_empty), int'(e.cnt == 0));
        chk(e.nm, "err",   int'(sb_err),   int'(e.err));
      end
    end
  end

  task automatic cyc(input string nm, input logic v,
                     input logic [4:0] r1, input logic u1, input logic [4:0] r2, input logic u2,
                     input logic [4:0] rd, input logic rw, input logic mr,
                     input logic wb, input logic [4:0] wrd, input logic fl, input logic [1:0] fc,
                     input logic es, input int ec, input logic ee);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    id_valid = v; id_rs1 = r1; id_uses_rs1 = u1; id_rs2 = r2; id_uses_rs2 = u2;
    id_rd = rd; id_RegWrite = rw; id_MemRead = mr;
    wb_RegWrite = wb; write_rd = wrd; flush = fl; flush_cnt = fc;
    e.nm = nm; e.stall = es; e.cnt = ec; e.err = ee;
    exp_q.push_back(e);
  endtask

  task automatic idle(input string nm, input int ec, input logic ee);
    cyc(nm, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ec, ee);
  endtask

  task automatic push_rd(input string nm, input logic [4:0] rd, input int ec, input logic ee);
    cyc(nm, 1, 0, 0, 0, 0, rd, 1, 0, 0, 0, 0, 0, 0, ec, ee);
  endtask

  task automatic rst_cycle(input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    id_valid = 0; id_rs1 = 0; id_uses_rs1 = 0; id_rs2 = 0; id_uses_rs2 = 0;
    id_rd = 0; id_RegWrite = 0; id_MemRead = 0;
    wb_RegWrite = 0; write_rd = 0; flush = 0; flush_cnt = 0;
    e.nm = nm; e.stall = 1'b0; e.cnt = 0; e.err = 1'b0;
    exp_q.push_back(e);
  endtask

  initial begin
    rst_n = 1'b0;
    id_valid = 0; id_rs1 = 0; id_uses_rs1 = 0; id_rs2 = 0; id_uses_rs2 = 0;
    id_rd = 0; id_RegWrite = 0; id_MemRead = 0;
    wb_RegWrite = 0; write_rd = 0; flush = 0; flush_cnt = 0;

    rst_cycle("reset");
    idle("t1_idle", 0, 0);
    // RAW on an ALU result: stalls only without forwarding, released in the WB cycle
    cyc("t1_add_x5",    1, 1, 1, 2, 1, 5, 1, 0, 0, 0, 0, 0, 0,  0, 0);
    cyc("t1_use_x5_a",  1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, NF, 1, 0);
    cyc("t1_use_x5_b",  1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, NF, 1, 0);
    cyc("t1_use_x5_wb", 1, 5, 1, 0, 0, 0, 0, 0, 1, 5, 0, 0, 0,  1, 0);
    idle("t1_done", 0, 0);
    // load-use
    cyc("t2_lw_x3",     1, 1, 1, 0, 0, 3, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    cyc("t2_add_stall", 1, 3, 1, 1, 1, 4, 1, 0, 0, 0, 0, 0, 1, 1, 0);
    cyc("t2_add_wb",    1, 3, 1, 1, 1, 4, 1, 0, 1, 3, 0, 0, 0, 1, 0);
    cyc("t2_wb_x4",     0, 0, 0, 0, 0, 0, 0, 0, 1, 4, 0, 0, 0, 1, 0);
    // fill to DEPTH, then full stall and push-with-pop
    push_rd("t3_push_x6", 6, 0, 0);
    push_rd("t3_push_x7", 7, 1, 0);
    push_rd("t3_push_x8", 8, 2, 0);
    push_rd("t3_push_x9", 9, 3, 0);
    cyc("t3_full_stall",    1, 0, 0, 0, 0, 10, 1, 0, 0, 0, 0, 0, 1, 4, 0);
    cyc("t3_full_pop_push", 1, 0, 0, 0, 0, 10, 1, 0, 1, 6, 0, 0, 0, 4, 0);
    cyc("t4_pop_x7",        0, 0, 0, 0, 0, 0,  0, 0, 1, 7, 0, 0, 0, 4, 0);
    // flush with pop; same-cycle writer dropped
    cyc("t4_flush2_pop",    1, 0, 0, 0, 0, 11, 1, 1, 1, 8, 1, 2, 0, 3, 0);
    push_rd("t4_refill_x12", 12, 0, 0);
    push_rd("t4_refill_x13", 13, 1, 0);
    push_rd("t4_refill_x14", 14, 2, 0);
    cyc("t4_flush3_pop",    1, 0, 0, 0, 0, 15, 1, 1, 1, 12, 1, 3, 0, 3, 0);
    cyc("t4_no_push_chk",   1, 15, 1, 11, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // WB on empty sets the sticky error
    cyc("t5_wb_empty",      0, 0, 0, 0, 0, 0, 0, 0, 1, 9, 0, 0, 0, 0, 0);
    idle("t5_err_sticky", 0, 1);
    push_rd("t6_fill_x6", 6, 0, 1);
    push_rd("t6_fill_x7", 7, 1, 1);
    push_rd("t6_fill_x8", 8, 2, 1);
    idle("t6_three", 3, 1);
    rst_cycle("t6_async_rst");
    idle("t6_after_rst", 0, 0);
    // WB rd differs from head rd
    push_rd("t5_push_x6", 6, 0, 0);
    cyc("t5_wb_mismatch",   0, 0, 0, 0, 0, 0, 0, 0, 1, 7, 0, 0, 0, 1, 0);
    idle("t5_mm_err", 0, 1);
    idle("t5_mm_sticky", 0, 1);
    // x0 is neither tracked nor a hazard source
    push_rd("t6_push_x6b", 6, 0, 1);
    cyc("t6_x0",            1, 0, 1, 0, 1, 0, 1, 1, 0, 0, 0, 0, 0, 1, 1);
    cyc("t6_x0_again",      1, 0, 1, 0, 1, 0, 1, 1, 0, 0, 0, 0, 0, 1, 1);
    idle("t6_end", 1, 1);

    repeat (4) @(negedge clk);
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
